// File: rtl/signal_generator_pkg.sv
// Shared constants, enums and command payload for the SignalGenerator programming sequencer.
package signal_generator_pkg;

    localparam int unsigned SeqLen = 8;
    localparam int unsigned IdxW   = 3;
    localparam int unsigned AddrW  = 16;
    localparam int unsigned DataW  = 32;

    localparam logic [AddrW-1:0] OffCtrl      = 16'h0000;
    localparam logic [AddrW-1:0] OffStartNs   = 16'h0040;
    localparam logic [AddrW-1:0] OffStartSec  = 16'h0044;
    localparam logic [AddrW-1:0] OffPulseNs   = 16'h0048;
    localparam logic [AddrW-1:0] OffPeriodNs  = 16'h0050;
    localparam logic [AddrW-1:0] OffPeriodSec = 16'h0054;
    localparam logic [AddrW-1:0] OffRepeat    = 16'h0058;

    typedef enum logic [1:0] {
        StatOk      = 2'd0,
        StatSlvErr  = 2'd1,
        StatTimeout = 2'd2,
        StatAbort   = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StResp   = 2'd2,
        StFinish = 2'd3
    } state_e;

    typedef struct packed {
        logic [DataW-1:0] start_sec;
        logic [DataW-1:0] start_ns;
        logic [DataW-1:0] pulse_ns;
        logic [DataW-1:0] period_sec;
        logic [DataW-1:0] period_ns;
        logic [DataW-1:0] repeat_cnt;
    } cmd_t;

    // Register offset of write slot idx; slots 0 and 7 both hit the control register.
    function automatic logic [AddrW-1:0] seq_offset(input logic [IdxW-1:0] idx);
        case (idx)
            3'd1:    return OffStartSec;
            3'd2:    return OffStartNs;
            3'd3:    return OffPulseNs;
            3'd4:    return OffPeriodSec;
            3'd5:    return OffPeriodNs;
            3'd6:    return OffRepeat;
            default: return OffCtrl;
        endcase
    endfunction

    function automatic logic [DataW-1:0] seq_data(input logic [IdxW-1:0] idx, input cmd_t cmd);
        case (idx)
            3'd1:    return cmd.start_sec;
            3'd2:    return cmd.start_ns;
            3'd3:    return cmd.pulse_ns;
            3'd4:    return cmd.period_sec;
            3'd5:    return cmd.period_ns;
            3'd6:    return cmd.repeat_cnt;
            3'd7:    return DataW'(1);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/signal_generator_sequencer_if.sv
// AXI4-Lite write channels between the sequencer (master) and the SignalGenerator s_axi port.
interface signal_generator_sequencer_if;

    logic        AxiWriteAddrValid_ValOut;
    logic        AxiWriteAddrReady_RdyIn;
    logic [15:0] AxiWriteAddrAddress_AdrOut;
    logic [2:0]  AxiWriteAddrProt_DatOut;
    logic        AxiWriteDataValid_ValOut;
    logic        AxiWriteDataReady_RdyIn;
    logic [31:0] AxiWriteDataData_DatOut;
    logic [3:0]  AxiWriteDataStrobe_DatOut;
    logic        AxiWriteRespValid_ValIn;
    logic        AxiWriteRespReady_RdyOut;
    logic [1:0]  AxiWriteRespResponse_DatIn;

    modport master (
        output AxiWriteAddrValid_ValOut, AxiWriteAddrAddress_AdrOut, AxiWriteAddrProt_DatOut,
        output AxiWriteDataValid_ValOut, AxiWriteDataData_DatOut, AxiWriteDataStrobe_DatOut,
        output AxiWriteRespReady_RdyOut,
        input  AxiWriteAddrReady_RdyIn, AxiWriteDataReady_RdyIn,
        input  AxiWriteRespValid_ValIn, AxiWriteRespResponse_DatIn
    );

    modport slave (
        input  AxiWriteAddrValid_ValOut, AxiWriteAddrAddress_AdrOut, AxiWriteAddrProt_DatOut,
        input  AxiWriteDataValid_ValOut, AxiWriteDataData_DatOut, AxiWriteDataStrobe_DatOut,
        input  AxiWriteRespReady_RdyOut,
        output AxiWriteAddrReady_RdyIn, AxiWriteDataReady_RdyIn,
        output AxiWriteRespValid_ValIn, AxiWriteRespResponse_DatIn
    );

endinterface

// File: rtl/axi_lite_write_engine.sv
// Single AXI4-Lite write: independent AW/W handshakes, B wait and a saturating response timer.
module axi_lite_write_engine
    import signal_generator_pkg::*;
#(
    parameter int unsigned RespTimeout_Gen = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [AddrW-1:0]      addr_i,
    input  logic [DataW-1:0]      data_i,
    signal_generator_sequencer_if.master axi,
    output logic                  addr_done_c_o,
    output logic                  done_c_o,
    output logic [1:0]            resp_c_o,
    output logic                  timeout_c_o
);

    localparam int unsigned TimerW = $clog2(RespTimeout_Gen + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(RespTimeout_Gen - 1);
    localparam logic [TimerW-1:0] TimerMax  = TimerW'(RespTimeout_Gen);

    logic              aw_valid_q, aw_valid_d;
    logic              w_valid_q, w_valid_d;
    logic              b_ready_q, b_ready_d;
    logic              active_q, active_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [AddrW-1:0]  addr_q, addr_d;
    logic [DataW-1:0]  data_q, data_d;

    logic aw_hs_c, w_hs_c, b_hs_c, aw_left_c, w_left_c;

    assign aw_hs_c   = aw_valid_q & axi.AxiWriteAddrReady_RdyIn;
    assign w_hs_c    = w_valid_q & axi.AxiWriteDataReady_RdyIn;
    assign b_hs_c    = b_ready_q & axi.AxiWriteRespValid_ValIn;
    assign aw_left_c = aw_valid_q & ~axi.AxiWriteAddrReady_RdyIn;
    assign w_left_c  = w_valid_q & ~axi.AxiWriteDataReady_RdyIn;

    // True on the edge where the later of AW/W completes.
    assign addr_done_c_o = active_q & ~b_ready_q & (aw_valid_q | w_valid_q) & ~aw_left_c & ~w_left_c;
    assign done_c_o      = b_hs_c;
    assign resp_c_o      = axi.AxiWriteRespResponse_DatIn;
    assign timeout_c_o   = active_q & ~b_hs_c & (timer_q == TimerLast);

    always_comb begin
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        b_ready_d  = b_ready_q;
        active_d   = active_q;
        timer_d    = timer_q;
        addr_d     = addr_q;
        data_d     = data_q;
        if (active_q) begin
            if (aw_hs_c)       aw_valid_d = 1'b0;
            if (w_hs_c)        w_valid_d  = 1'b0;
            if (addr_done_c_o) b_ready_d  = 1'b1;
            if (b_hs_c) begin
                b_ready_d = 1'b0;
                active_d  = 1'b0;
            end
            if (timer_q != TimerMax) timer_d = TimerW'(timer_q + 1'b1);
            if (timeout_c_o) begin
                aw_valid_d = 1'b0;
                w_valid_d  = 1'b0;
                b_ready_d  = 1'b0;
                active_d   = 1'b0;
            end
        end
        if (start_i) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            b_ready_d  = 1'b0;
            active_d   = 1'b1;
            timer_d    = '0;
            addr_d     = addr_i;
            data_d     = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            active_q   <= 1'b0;
            timer_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            b_ready_q  <= b_ready_d;
            active_q   <= active_d;
            timer_q    <= timer_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign axi.AxiWriteAddrValid_ValOut   = aw_valid_q;
    assign axi.AxiWriteAddrAddress_AdrOut = addr_q;
    assign axi.AxiWriteAddrProt_DatOut    = 3'b000;
    assign axi.AxiWriteDataValid_ValOut   = w_valid_q;
    assign axi.AxiWriteDataData_DatOut    = data_q;
    assign axi.AxiWriteDataStrobe_DatOut  = 4'hF;
    assign axi.AxiWriteRespReady_RdyOut   = b_ready_q;

endmodule

// File: rtl/signal_generator_sequencer.sv
// Command-driven sequencer that programs one SignalGenerator through a fixed eight-write AXI4-Lite sequence.
module signal_generator_sequencer
    import signal_generator_pkg::*;
#(
    parameter logic [AddrW-1:0] BaseAddr_Gen    = 16'h0000,
    parameter int unsigned      RespTimeout_Gen = 1024
) (
    input  logic             SysClk_ClkIn,
    input  logic             SysRstN_RstIn,
    input  logic             CmdValid_ValIn,
    output logic             CmdReady_RdyOut,
    input  logic [DataW-1:0] CmdStartSecond_DatIn,
    input  logic [DataW-1:0] CmdStartNanosecond_DatIn,
    input  logic [DataW-1:0] CmdPulseNanosecond_DatIn,
    input  logic [DataW-1:0] CmdPeriodSecond_DatIn,
    input  logic [DataW-1:0] CmdPeriodNanosecond_DatIn,
    input  logic [DataW-1:0] CmdRepeat_DatIn,
    input  logic             CmdAbort_EvtIn,
    output logic             Busy_DatOut,
    output logic             Done_EvtOut,
    output logic [1:0]       Status_DatOut,
    signal_generator_sequencer_if.master axi
);

    state_e          state_q, state_d;
    cmd_t            cmd_q, cmd_d, cmd_in_c;
    logic [IdxW-1:0] idx_q, idx_d;
    status_e         status_q, status_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            abort_q, abort_d;
    logic            abort_wr_q, abort_wr_d;

    logic             accept_c, start_c;
    logic [AddrW-1:0] wr_addr_c;
    logic [DataW-1:0] wr_data_c;
    logic             addr_done_c, wr_done_c, timeout_c;
    logic [1:0]       wr_resp_c;

    assign cmd_in_c = {CmdStartSecond_DatIn, CmdStartNanosecond_DatIn, CmdPulseNanosecond_DatIn,
                       CmdPeriodSecond_DatIn, CmdPeriodNanosecond_DatIn, CmdRepeat_DatIn};
    assign accept_c = (state_q == StIdle) & CmdValid_ValIn & cmd_ready_q;

    axi_lite_write_engine #(
        .RespTimeout_Gen(RespTimeout_Gen)
    ) u_engine (
        .clk_i        (SysClk_ClkIn),
        .rst_ni       (SysRstN_RstIn),
        .start_i      (start_c),
        .addr_i       (wr_addr_c),
        .data_i       (wr_data_c),
        .axi          (axi),
        .addr_done_c_o(addr_done_c),
        .done_c_o     (wr_done_c),
        .resp_c_o     (wr_resp_c),
        .timeout_c_o  (timeout_c)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        idx_d       = idx_q;
        status_d    = status_q;
        cmd_ready_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        abort_d     = abort_q | (CmdAbort_EvtIn & busy_q);
        abort_wr_d  = abort_wr_q;
        start_c     = 1'b0;
        wr_addr_c   = BaseAddr_Gen + OffCtrl;
        wr_data_c   = '0;
        case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                if (accept_c) begin
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    status_d    = StatOk;
                    cmd_d       = cmd_in_c;
                    idx_d       = '0;
                    abort_d     = 1'b0;
                    abort_wr_d  = 1'b0;
                    start_c     = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (timeout_c) begin
                    status_d = StatTimeout;
                    state_d  = StFinish;
                end else if (addr_done_c) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (timeout_c) begin
                    status_d = StatTimeout;
                    state_d  = StFinish;
                end else if (wr_done_c) begin
                    // Error beats abort; a pending abort always gets its own disable write.
                    if (wr_resp_c != 2'b00) begin
                        status_d = StatSlvErr;
                        state_d  = StFinish;
                    end else if (abort_wr_q) begin
                        status_d = StatAbort;
                        state_d  = StFinish;
                    end else if (abort_d) begin
                        abort_wr_d = 1'b1;
                        start_c    = 1'b1;
                        state_d    = StIssue;
                    end else if (idx_q == IdxW'(SeqLen - 1)) begin
                        status_d = StatOk;
                        state_d  = StFinish;
                    end else begin
                        idx_d     = IdxW'(idx_q + 1'b1);
                        start_c   = 1'b1;
                        wr_addr_c = BaseAddr_Gen + seq_offset(idx_d);
                        wr_data_c = seq_data(idx_d, cmd_q);
                        state_d   = StIssue;
                    end
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            idx_q       <= '0;
            status_q    <= StatOk;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            abort_wr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            idx_q       <= idx_d;
            status_q    <= status_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            abort_wr_q  <= abort_wr_d;
        end
    end

    assign CmdReady_RdyOut = cmd_ready_q;
    assign Busy_DatOut     = busy_q;
    assign Done_EvtOut     = done_q;
    assign Status_DatOut   = status_q;

endmodule

// File: tb/tb_signal_generator_sequencer.sv
// Directed bench: scripted AXI slave with per-write delays/responses, command scenarios with hand-computed results.
module tb_signal_generator_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] c_ss = '0, c_sns = '0, c_pns = '0, c_psec = '0, c_pern = '0, c_rep = '0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [1:0]  status;

    signal_generator_sequencer_if axi ();

    signal_generator_sequencer #(
        .BaseAddr_Gen   (16'h0000),
        .RespTimeout_Gen(16)
    ) dut (
        .SysClk_ClkIn             (clk),
        .SysRstN_RstIn            (rst_n),
        .CmdValid_ValIn           (cmd_valid),
        .CmdReady_RdyOut          (cmd_ready),
        .CmdStartSecond_DatIn     (c_ss),
        .CmdStartNanosecond_DatIn (c_sns),
        .CmdPulseNanosecond_DatIn (c_pns),
        .CmdPeriodSecond_DatIn    (c_psec),
        .CmdPeriodNanosecond_DatIn(c_pern),
        .CmdRepeat_DatIn          (c_rep),
        .CmdAbort_EvtIn           (abort),
        .Busy_DatOut              (busy),
        .Done_EvtOut              (done),
        .Status_DatOut            (status),
        .axi                      (axi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scripted slave configuration and state
    int          aw_dly [8];
    int          w_dly  [8];
    logic [1:0]  bresp_at [8];
    int          b_never_idx;
    int          wr_n, aw_cnt, w_cnt, unstable, split;
    bit          aw_got, w_got, aw_seen, w_seen;
    logic [15:0] aw_first;
    logic [31:0] w_first;
    logic [15:0] aw_log [$];
    logic [31:0] w_log  [$];
    logic [15:0] exp_a  [8];
    logic [31:0] exp_d  [8];
    logic [15:0] def_a  [8] = '{16'h0000, 16'h0044, 16'h0040, 16'h0048, 16'h0054, 16'h0050, 16'h0058, 16'h0000};
    int          accept_cyc;
    int          done_cnt = 0;

    task automatic clear_slave();
        for (int i = 0; i < 8; i++) begin
            aw_dly[i]   = 0;
            w_dly[i]    = 0;
            bresp_at[i] = 2'b00;
        end
        b_never_idx = -1;
        wr_n = 0; aw_cnt = 0; w_cnt = 0; unstable = 0; split = 0;
        aw_got = 0; w_got = 0; aw_seen = 0; w_seen = 0;
        aw_log.delete();
        w_log.delete();
        axi.AxiWriteAddrReady_RdyIn    = 1'b0;
        axi.AxiWriteDataReady_RdyIn    = 1'b0;
        axi.AxiWriteRespValid_ValIn    = 1'b0;
        axi.AxiWriteRespResponse_DatIn = 2'b00;
    endtask

    // Slave decisions at negedge; a ready/valid pair seen here completes at the next posedge.
    initial begin
        clear_slave();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                clear_slave();
            end else begin
                int k;
                k = (wr_n > 7) ? 7 : wr_n;
                if (aw_got && w_got && (wr_n != b_never_idx)) begin
                    axi.AxiWriteRespValid_ValIn    = 1'b1;
                    axi.AxiWriteRespResponse_DatIn = bresp_at[k];
                    if (axi.AxiWriteRespReady_RdyOut) begin
                        wr_n++;
                        aw_got = 0;
                        w_got  = 0;
                    end
                end else begin
                    axi.AxiWriteRespValid_ValIn = 1'b0;
                end
                axi.AxiWriteAddrReady_RdyIn = 1'b0;
                if (axi.AxiWriteAddrValid_ValOut && !aw_got) begin
                    if (!aw_seen) begin
                        aw_seen  = 1;
                        aw_first = axi.AxiWriteAddrAddress_AdrOut;
                    end else if (axi.AxiWriteAddrAddress_AdrOut !== aw_first) unstable++;
                    if (axi.AxiWriteAddrProt_DatOut !== 3'b000) unstable++;
                    if (aw_cnt >= aw_dly[k]) begin
                        axi.AxiWriteAddrReady_RdyIn = 1'b1;
                        aw_got = 1; aw_seen = 0; aw_cnt = 0;
                        aw_log.push_back(axi.AxiWriteAddrAddress_AdrOut);
                    end else aw_cnt++;
                end
                axi.AxiWriteDataReady_RdyIn = 1'b0;
                if (axi.AxiWriteDataValid_ValOut && !w_got) begin
                    if (!w_seen) begin
                        w_seen  = 1;
                        w_first = axi.AxiWriteDataData_DatOut;
                    end else if (axi.AxiWriteDataData_DatOut !== w_first) unstable++;
                    if (axi.AxiWriteDataStrobe_DatOut !== 4'hF) unstable++;
                    if (w_cnt >= w_dly[k]) begin
                        axi.AxiWriteDataReady_RdyIn = 1'b1;
                        w_got = 1; w_seen = 0; w_cnt = 0;
                        w_log.push_back(axi.AxiWriteDataData_DatOut);
                    end else w_cnt++;
                end
                if (axi.AxiWriteAddrValid_ValOut != axi.AxiWriteDataValid_ValOut) split++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
    end

    task automatic send_cmd(input logic [31:0] ss, sns, pn, ps, pern, rp);
        int k = 0;
        exp_d = '{32'd0, ss, sns, pn, ps, pern, rp, 32'd1};
        for (int i = 0; i < 8; i++) exp_a[i] = def_a[i];
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_val("cmd_ready_before_send", 32'(cmd_ready), 32'd1);
        c_ss = ss; c_sns = sns; c_pns = pn; c_psec = ps; c_pern = pern; c_rep = rp;
        cmd_valid  = 1'b1;
        accept_cyc = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int rel, output logic [1:0] st);
        bit seen = 0;
        rel = -1;
        st  = 2'b00;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                rel  = cyc - accept_cyc;
                st   = status;
            end
        end
        check_val("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_log(input int n);
        check_val("aw_count", 32'(aw_log.size()), 32'(n));
        check_val("w_count", 32'(w_log.size()), 32'(n));
        for (int i = 0; i < n && i < aw_log.size() && i < w_log.size(); i++) begin
            check_val($sformatf("addr[%0d]", i), 32'(aw_log[i]), 32'(exp_a[i]));
            check_val($sformatf("data[%0d]", i), w_log[i], exp_d[i]);
        end
        check_val("stable_and_const", 32'(unstable), 32'd0);
    endtask

    task automatic wait_rel(input int n);
        while (cyc < accept_cyc + n) @(negedge clk);
    endtask

    initial begin
        int         rel;
        logic [1:0] st;
        int         dc;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_ready", 32'(cmd_ready), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_status", 32'(status), 32'd0);
        check_val("rst_awvalid", 32'(axi.AxiWriteAddrValid_ValOut), 32'd0);
        check_val("rst_wvalid", 32'(axi.AxiWriteDataValid_ValOut), 32'd0);
        check_val("rst_bready", 32'(axi.AxiWriteRespReady_RdyOut), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("ready_after_release", 32'(cmd_ready), 32'd1);

        // Zero-wait slave
        clear_slave();
        send_cmd(32'd5, 32'd100, 32'd1000, 32'd1, 32'd0, 32'd10);
        check_val("busy_after_accept", 32'(busy), 32'd1);
        wait_done(60, rel, st);
        check_val("t1_done_cycle", 32'(rel), 32'd17);
        check_val("t1_status", 32'(st), 32'd0);
        check_val("t1_busy_at_done", 32'(busy), 32'd0);
        check_val("t1_ready_at_done", 32'(cmd_ready), 32'd0);
        check_log(8);
        @(negedge clk);
        check_val("t1_ready_after_done", 32'(cmd_ready), 32'd1);
        check_val("t1_status_held", 32'(status), 32'd0);

        // Skewed handshakes, alternating direction
        clear_slave();
        for (int i = 0; i < 8; i++) begin
            aw_dly[i] = (i % 2 == 1) ? 3 : 0;
            w_dly[i]  = (i % 2 == 1) ? 0 : 3;
        end
        send_cmd(32'd7, 32'd999_999_999, 32'd500, 32'd0, 32'd250_000_000, 32'd0);
        wait_done(120, rel, st);
        check_val("t2_done_cycle", 32'(rel), 32'd41);
        check_val("t2_status", 32'(st), 32'd0);
        check_val("t2_split_valids", 32'(split > 8), 32'd1);
        check_log(8);

        // Slave error on W3
        clear_slave();
        bresp_at[3] = 2'b10;
        send_cmd(32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4);
        wait_done(60, rel, st);
        check_val("t3_done_cycle", 32'(rel), 32'd9);
        check_val("t3_status", 32'(st), 32'd1);
        repeat (3) @(negedge clk);
        check_log(4);

        // Timeout on W5 (RespTimeout_Gen = 16)
        clear_slave();
        b_never_idx = 5;
        send_cmd(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6);
        wait_rel(25);
        check_val("t4_bready_before_to", 32'(axi.AxiWriteRespReady_RdyOut), 32'd1);
        @(negedge clk);
        check_val("t4_bready_after_to", 32'(axi.AxiWriteRespReady_RdyOut), 32'd0);
        check_val("t4_awvalid_after_to", 32'(axi.AxiWriteAddrValid_ValOut), 32'd0);
        check_val("t4_wvalid_after_to", 32'(axi.AxiWriteDataValid_ValOut), 32'd0);
        wait_done(20, rel, st);
        check_val("t4_done_cycle", 32'(rel), 32'd27);
        check_val("t4_status", 32'(st), 32'd2);
        check_val("t4_b_count", 32'(wr_n), 32'd5);
        check_val("t4_aw_count", 32'(aw_log.size()), 32'd6);

        // Abort during W2
        clear_slave();
        send_cmd(32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66);
        wait_rel(4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(60, rel, st);
        check_val("t5_done_cycle", 32'(rel), 32'd9);
        check_val("t5_status", 32'(st), 32'd3);
        exp_a[3] = 16'h0000;
        exp_d[3] = 32'd0;
        check_log(4);

        // New command after abort; a stray abort in Idle is ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        clear_slave();
        send_cmd(32'd3, 32'd30, 32'd300, 32'd2, 32'd20, 32'd1);
        wait_done(60, rel, st);
        check_val("t6_done_cycle", 32'(rel), 32'd17);
        check_val("t6_status", 32'(st), 32'd0);
        check_log(8);

        // Reset during W4 issue
        clear_slave();
        send_cmd(32'd5, 32'd100, 32'd1000, 32'd1, 32'd0, 32'd10);
        wait_rel(8);
        check_val("t7_awvalid_in_w4", 32'(axi.AxiWriteAddrValid_ValOut), 32'd1);
        dc = done_cnt;
        #1 rst_n = 1'b0;
        #1;
        check_val("t7_awvalid_rst", 32'(axi.AxiWriteAddrValid_ValOut), 32'd0);
        check_val("t7_wvalid_rst", 32'(axi.AxiWriteDataValid_ValOut), 32'd0);
        check_val("t7_bready_rst", 32'(axi.AxiWriteRespReady_RdyOut), 32'd0);
        check_val("t7_busy_rst", 32'(busy), 32'd0);
        check_val("t7_ready_rst", 32'(cmd_ready), 32'd0);
        check_val("t7_status_rst", 32'(status), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("t7_ready_after_release", 32'(cmd_ready), 32'd1);
        repeat (4) @(negedge clk);
        check_val("t7_no_done_pulse", 32'(done_cnt), 32'(dc));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

endmodule
